// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU-side memory and IO target.
//   - Byte RAM of 2^RAM_ADDR_WIDTH bytes with a registered read port.
//   - IO page (mem_a[17:16] == 2'b11):
//       0x30000 write: nonzero byte goes to the UART TX FIFO
//       0x30000 read : UART RX byte (only with RX_INPUT_EN), else 0x00
//       0x30004 write: queue a 0x00 terminator and start draining
//       0x30004..7 read: cycle counter bytes; 0x30004 latches a snapshot
//         that 0x30005..7 then return.
//   - sim_done rises once the terminator and everything ahead of it
//     have left the FIFO.
// Optional feature macro: RX_INPUT_EN (UART receive path).
// Ports:
//   clk_in, rst_in (async, active-low)
//   rdy_in, mem_a, mem_wr, mem_dout -> CPU request, mem_din <- read data
//   tx_data/tx_valid/tx_ready         UART transmit handshake
//   rx_data/rx_valid -> rx_pop        UART receive byte and pop strobe
//   io_buffer_full                    TX FIFO nearly full
//   sim_done                          program stopped, output drained
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_DEPTH  = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        sim_done
);

  localparam int          AW        = $clog2(TX_FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(1) << RAM_ADDR_WIDTH;
  localparam logic [17:0] IO_UART   = 18'h30000;
  localparam logic [17:0] IO_CNT    = 18'h30004;
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(TX_FIFO_DEPTH);
  // Two entries of margin for writes already issued by the CPU.
  localparam logic [AW:0] NEAR_CNT  = (AW+1)'(TX_FIFO_DEPTH - 2);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t r_state, w_state_nxt;

  logic [17:0]               w_addr;
  logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;
  logic                      w_io_sel, w_ram_sel, w_rd, w_wr;
  logic                      w_io_wr, w_halt_wr;
  logic [7:0]                w_rd_data;
  logic                      w_unused;

  logic [7:0]  r_ram [RAM_BYTES];
  logic [7:0]  r_dout;
  logic [31:0] r_cnt, r_snap;

  logic [7:0]  r_fifo [TX_FIFO_DEPTH];
  logic [AW:0] r_wp, r_rp, w_count;
  logic        w_push_req, w_push, w_pop;
  logic [7:0]  w_push_data;

  // Address decode: only bits 17:0 matter; IO page wins over RAM.
  assign w_addr    = mem_a[17:0];
  assign w_ram_idx = w_addr[RAM_ADDR_WIDTH-1:0];
  assign w_io_sel  = (w_addr[17:16] == 2'b11);
  assign w_ram_sel = !w_io_sel && ({14'd0, w_addr} < RAM_BYTES);
  assign w_rd      = rdy_in && !mem_wr;
  assign w_wr      = rdy_in && mem_wr;

  // IO writes only act while running; after the stop request they are dropped.
  assign w_io_wr   = w_wr && w_io_sel && (r_state == S_RUN);
  assign w_halt_wr = w_io_wr && (w_addr == IO_CNT);

  // RAM write port; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (w_wr && w_ram_sel) r_ram[w_ram_idx] <= mem_dout;
  end

`ifdef RX_INPUT_EN
  logic w_rx_take, r_rx_pop;
  assign w_rx_take = w_rd && w_io_sel && (w_addr == IO_UART) && rx_valid;
  assign rx_pop    = r_rx_pop;
  assign w_unused  = ^mem_a[31:18];
`else
  assign rx_pop    = 1'b0;
  assign w_unused  = ^{mem_a[31:18], rx_data, rx_valid};
`endif

  // Read data source for the current request.
  always_comb begin
    w_rd_data = 8'h00;
    if (w_ram_sel) begin
      w_rd_data = r_ram[w_ram_idx];
    end else if (w_io_sel) begin
`ifdef RX_INPUT_EN
      if (w_addr == IO_UART && rx_valid) w_rd_data = rx_data;
`endif
      if (w_addr[17:2] == IO_CNT[17:2]) begin
        case (w_addr[1:0])
          2'd0:    w_rd_data = r_cnt[7:0];   // same value the snapshot captures
          2'd1:    w_rd_data = r_snap[15:8];
          2'd2:    w_rd_data = r_snap[23:16];
          default: w_rd_data = r_snap[31:24];
        endcase
      end
    end
  end

  // Registered read data, free-running counter, snapshot.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_dout <= 8'h00;
      r_cnt  <= 32'd0;
      r_snap <= 32'd0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_rd) r_dout <= w_rd_data;
      if (w_rd && w_io_sel && w_addr == IO_CNT) r_snap <= r_cnt;
    end
  end

`ifdef RX_INPUT_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_rx_pop <= 1'b0;
    else         r_rx_pop <= w_rx_take;
  end
`endif

  assign mem_din = r_dout;

  // TX FIFO: pointers carry one extra bit so full and empty differ.
  assign w_count        = r_wp - r_rp;
  assign tx_valid       = (w_count != '0);
  assign tx_data        = r_fifo[r_rp[AW-1:0]];
  assign io_buffer_full = (w_count >= NEAR_CNT);
  assign w_pop          = tx_valid && tx_ready;
  // A push into a full FIFO is dropped even if a pop happens that cycle.
  assign w_push         = w_push_req && (w_count != FULL_CNT);

  always_ff @(posedge clk_in) begin
    if (w_push) r_fifo[r_wp[AW-1:0]] <= w_push_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= S_RUN;
    else         r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:    if (w_halt_wr) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_count == '0) w_state_nxt = S_HALTED;
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_RUN;
    endcase
  end

  // FSM: outputs. The stop write queues a 0x00 terminator, bypassing
  // the rule that zero bytes are not transmitted.
  always_comb begin
    sim_done    = (r_state == S_HALTED);
    w_push_req  = 1'b0;
    w_push_data = mem_dout;
    if (w_halt_wr) begin
      w_push_req  = 1'b1;
      w_push_data = 8'h00;
    end else if (w_io_wr && w_addr == IO_UART && mem_dout != 8'h00) begin
      w_push_req  = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

`ifdef RX_INPUT_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b0, mem_wr = 1'b0;
  logic        tx_ready = 1'b0, rx_valid = 1'b0;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_dout = '0, rx_data = '0;
  logic [7:0]  mem_din, tx_data;
  logic        io_buffer_full, tx_valid, rx_pop, sim_done;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
    .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_pop(rx_pop), .sim_done(sim_done)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, failures = 0;

  // Reference cycle count: edges seen since reset release.
  int unsigned m_cyc;
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) m_cyc <= 0;
    else         m_cyc <= m_cyc + 1;
  end

  typedef struct {
    logic        rdy;
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t        tbl[16];
  logic [7:0]  exp_q[$];
  logic [31:0] exp32;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // One request cycle, then the bus goes idle (rdy_in low).
  task automatic op(input logic rdy, input logic wr, input logic [31:0] a, input logic [7:0] d);
    rdy_in = rdy; mem_wr = wr; mem_a = a; mem_dout = d;
    cyc();
    rdy_in = 1'b0; mem_wr = 1'b0;
  endtask

  // Collect bytes leaving the TX port (tx_ready must already be high).
  task automatic drain(input string nm, input int n);
    int got = 0;
    for (int i = 0; i < 40; i++) begin
      if (tx_valid) begin
        if (exp_q.size() > 0) chk(nm, 32'(tx_data), 32'(exp_q.pop_front()));
        got++;
      end else if (got >= n) begin
        break;
      end
      cyc();
    end
    chk({nm, " count"}, 32'(got), 32'(n));
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'h0000_0010, 8'hA5, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 8'h00, 1'b1, 8'hA5};
    tbl[2]  = '{1'b1, 1'b1, 32'h0001_FFFF, 8'h3C, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 32'h0000_0000, 8'h7E, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 32'h0001_FFFF, 8'h00, 1'b1, 8'h3C};
    tbl[5]  = '{1'b1, 1'b1, 32'h0002_0000, 8'h99, 1'b0, 8'h00};  // unmapped write
    tbl[6]  = '{1'b1, 1'b0, 32'h0002_0000, 8'h00, 1'b1, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0000, 8'h00, 1'b1, 8'h7E};  // not clobbered
    tbl[8]  = '{1'b1, 1'b0, 32'h0002_FFFF, 8'h00, 1'b1, 8'h00};
    tbl[9]  = '{1'b1, 1'b1, 32'hFFF0_0010, 8'h11, 1'b0, 8'h00};  // upper bits ignored
    tbl[10] = '{1'b1, 1'b0, 32'h0000_0010, 8'h00, 1'b1, 8'h11};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_0000, 8'h55, 1'b0, 8'h00};  // rdy low: ignored
    tbl[12] = '{1'b0, 1'b0, 32'h0002_0000, 8'h00, 1'b1, 8'h11};  // rdy low: held
    tbl[13] = '{1'b1, 1'b0, 32'h0000_0000, 8'h00, 1'b1, 8'h7E};
    tbl[14] = '{1'b1, 1'b0, 32'h0003_0008, 8'h00, 1'b1, 8'h00};  // unused IO reg
    tbl[15] = '{1'b1, 1'b0, 32'h0001_FFFF, 8'h00, 1'b1, 8'h3C};

    // Reset state
    repeat (3) cyc();
    chk("rst mem_din", 32'(mem_din), 32'h00);
    chk("rst rx_pop", 32'(rx_pop), 32'd0);
    chk("rst tx_valid", 32'(tx_valid), 32'd0);
    chk("rst sim_done", 32'(sim_done), 32'd0);
    chk("rst io_buffer_full", 32'(io_buffer_full), 32'd0);
    rst_in = 1'b1;

    // Cycle counter snapshot about 100 cycles after release
    while (m_cyc < 100) cyc();
    exp32 = m_cyc;
    op(1, 0, 32'h30004, 0); chk("cnt b0", 32'(mem_din), 32'(exp32[7:0]));
    op(1, 0, 32'h30005, 0); chk("cnt b1", 32'(mem_din), 32'(exp32[15:8]));
    op(1, 0, 32'h30006, 0); chk("cnt b2", 32'(mem_din), 32'(exp32[23:16]));
    op(1, 0, 32'h30007, 0); chk("cnt b3", 32'(mem_din), 32'(exp32[31:24]));
    // Snapshot must hold while the live counter moves into the next byte.
    while (m_cyc < 32'h1F0) cyc();
    exp32 = m_cyc;
    op(1, 0, 32'h30004, 0); chk("snap2 b0", 32'(mem_din), 32'(exp32[7:0]));
    repeat (40) cyc();
    op(1, 0, 32'h30005, 0); chk("snap2 b1 held", 32'(mem_din), 32'(exp32[15:8]));

    // RAM / unmapped table
    for (int i = 0; i < 16; i++) begin
      op(tbl[i].rdy, tbl[i].wr, tbl[i].a, tbl[i].d);
      if (tbl[i].chk) chk($sformatf("tbl[%0d] mem_din", i), 32'(mem_din), 32'(tbl[i].exp));
    end

    // Zero byte to the UART is not queued
    op(1, 1, 32'h30000, 8'h00);
    cyc();
    chk("zero write tx_valid", 32'(tx_valid), 32'd0);

    // Fill toward full with tx_ready low
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      op(1, 1, 32'h30000, 8'h41);
      exp_q.push_back(8'h41);
      chk($sformatf("near full after push %0d", i + 1), 32'(io_buffer_full), 32'(i >= 5));
    end
    op(1, 1, 32'h30000, 8'h42); exp_q.push_back(8'h42);
    op(1, 1, 32'h30000, 8'h43); exp_q.push_back(8'h43);
    op(1, 1, 32'h30000, 8'h44);  // ninth push: FIFO full, dropped
    chk("full tx_valid", 32'(tx_valid), 32'd1);
    chk("full tx_data head", 32'(tx_data), 32'h41);
    tx_ready = 1'b1;
    drain("fifo drain", 8);
    chk("after drain near full", 32'(io_buffer_full), 32'd0);

    // Simultaneous push and pop keeps occupancy
    tx_ready = 1'b0;
    op(1, 1, 32'h30000, 8'h51);
    tx_ready = 1'b1;
    op(1, 1, 32'h30000, 8'h52);
    exp_q.push_back(8'h52);
    drain("push+pop", 1);
    tx_ready = 1'b0;

    // UART receive
    op(1, 0, 32'h00010, 0);
    chk("pre rx mem_din", 32'(mem_din), 32'h11);
    rx_valid = 1'b1; rx_data = 8'h37;
    op(1, 0, 32'h30000, 0);
    chk("rx mem_din", 32'(mem_din), RX_EN ? 32'h37 : 32'h00);
    chk("rx pop pulse", 32'(rx_pop), 32'(RX_EN));
    cyc();
    chk("rx pop one cycle", 32'(rx_pop), 32'd0);
    op(1, 0, 32'h00010, 0);
    op(0, 0, 32'h30000, 0);
    chk("rx rdy low pop", 32'(rx_pop), 32'd0);
    chk("rx rdy low mem_din", 32'(mem_din), 32'h11);
    rx_valid = 1'b0;
    op(1, 0, 32'h30000, 0);
    chk("rx empty mem_din", 32'(mem_din), 32'h00);
    chk("rx empty pop", 32'(rx_pop), 32'd0);

    // Stop request: terminator after queued bytes, then sim_done
    op(1, 1, 32'h30000, 8'h61);
    op(1, 1, 32'h30000, 8'h62);
    op(1, 1, 32'h30000, 8'h63);
    op(1, 1, 32'h30004, 8'hFF);
    chk("drain sim_done low", 32'(sim_done), 32'd0);
    tx_ready = 1'b1;
    exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    exp_q.push_back(8'h63); exp_q.push_back(8'h00);
    drain("halt drain", 4);
    for (int i = 0; i < 5 && !sim_done; i++) cyc();
    chk("sim_done", 32'(sim_done), 32'd1);
    tx_ready = 1'b0;
    op(1, 1, 32'h30000, 8'h55);
    op(1, 1, 32'h30004, 8'h09);
    cyc();
    chk("halted write ignored", 32'(tx_valid), 32'd0);
    chk("sim_done held", 32'(sim_done), 32'd1);
    op(1, 1, 32'h00020, 8'hC3);
    op(1, 0, 32'h00020, 0);
    chk("halted RAM read", 32'(mem_din), 32'hC3);

    // Reset mid-operation
    rst_in = 1'b0; #2;
    chk("reset2 sim_done", 32'(sim_done), 32'd0);
    chk("reset2 mem_din", 32'(mem_din), 32'h00);
    cyc();
    rst_in = 1'b1;
    op(1, 0, 32'h00020, 0);
    chk("post reset RAM kept", 32'(mem_din), 32'hC3);
    op(1, 1, 32'h30000, 8'h71);
    op(1, 1, 32'h30000, 8'h72);
    chk("run after reset tx_valid", 32'(tx_valid), 32'd1);
    rdy_in = 1'b1; mem_wr = 1'b0; mem_a = 32'h00020;
    #2 rst_in = 1'b0;
    #1;
    chk("async reset mem_din", 32'(mem_din), 32'h00);
    chk("async reset tx_valid", 32'(tx_valid), 32'd0);
    rdy_in = 1'b0;
    cyc();
    rst_in = 1'b1;
    cyc();
    chk("aborted read mem_din", 32'(mem_din), 32'h00);
    chk("fifo discarded", 32'(tx_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter RAM_ADDR_WIDTH, default 17, SHALL set the RAM size to 2^RAM_ADDR_WIDTH bytes.
REQ-002 Parameter TX_FIFO_DEPTH, default 8 (power of two, >=4), SHALL set the UART transmit FIFO depth in bytes.
REQ-003 clk_in  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low.
REQ-005 rdy_in  input  1  CPU ready; while low the block SHALL ignore mem_a, mem_wr and mem_dout.
REQ-006 mem_a  input  32  byte address from the CPU; only bits 17:0 SHALL be decoded.
REQ-007 mem_wr  input  1  1 = write, 0 = read.
REQ-008 mem_dout  input  8  write data from the CPU.
REQ-009 mem_din  output  8  read data to the CPU.
REQ-010 io_buffer_full  output  1  transmit path nearly full.
REQ-011 tx_data  output  8, tx_valid  output  1, tx_ready  input  1  UART transmit handshake.
REQ-012 rx_data  input  8, rx_valid  input  1, rx_pop  output  1  UART receive byte and its one-cycle pop strobe.
REQ-013 sim_done  output  1  program has stopped and all output has drained.

Function
REQ-014 Decode: mem_a[17:16]==2'b11 SHALL select IO; any other address below 2^RAM_ADDR_WIDTH SHALL select RAM; all remaining addresses SHALL be unmapped.
REQ-015 RAM read, rdy_in high: mem_din SHALL present the byte at mem_a exactly one cycle later (registered output).
REQ-016 RAM write, rdy_in high: the byte SHALL be stored at the same edge, so a read of that address in the next cycle returns the new value.
REQ-017 Unmapped access: a read SHALL return 0x00 next cycle; a write SHALL have no effect.
REQ-018 IO write 0x30000 with nonzero data SHALL push the byte into the TX FIFO; data 0x00 SHALL be ignored.
REQ-019 IO read 0x30000: if rx_valid, mem_din SHALL be rx_data next cycle and rx_pop SHALL pulse for one cycle; otherwise mem_din SHALL be 0x00 and rx_pop SHALL stay low.
REQ-020 IO read 0x30004+k, k=0..3, SHALL return byte k (little-endian) of the cycle count; a read at k=0 SHALL latch a snapshot that k=1..3 then return.
REQ-021 The cycle counter SHALL be 32 bits wide, SHALL increment every clk_in cycle after reset including cycles with rdy_in low, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-022 TX FIFO: tx_valid SHALL equal "FIFO not empty"; tx_data SHALL be the head byte; the head SHALL pop when tx_valid and tx_ready are both high.
REQ-023 io_buffer_full SHALL be high while FIFO occupancy >= TX_FIFO_DEPTH-2, leaving two entries of margin for requests already in flight.
REQ-024 A push into a full FIFO SHALL drop the byte; a simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-025 State machine RUN/DRAIN/HALTED: an IO write to 0x30004 in RUN SHALL push 0x00 (bypassing REQ-018) and move to DRAIN.
REQ-026 DRAIN SHALL move to HALTED when the FIFO becomes empty; HALTED SHALL hold sim_done high until reset.
REQ-027 In DRAIN and HALTED, further IO writes SHALL be ignored; RAM accesses SHALL still be served.

Reset
REQ-028 While rst_in is low: mem_din=0x00, rx_pop=0, tx_valid=0, sim_done=0, io_buffer_full=0, FIFO empty, counter=0, snapshot=0, state=RUN.
REQ-029 Reset asserted mid-operation SHALL abort any in-flight read and discard FIFO contents; RAM contents SHALL NOT be cleared.

Configuration
REQ-030 Macro RX_INPUT_EN defined: REQ-019 SHALL apply; undefined: reads of 0x30000 SHALL return 0x00, rx_pop SHALL be tied 0, and rx_data/rx_valid SHALL be unused.

Verification
REQ-031 Write 0xA5 to 0x00010, then read 0x00010 the next cycle -> mem_din=0xA5 one cycle after the read.
REQ-032 With tx_ready held 0, write 0x41 six times to 0x30000 (depth 8) -> io_buffer_full rises after the 6th push; a 9th write is dropped; FIFO drains 0x41 in order once tx_ready=1.
REQ-033 Write 0x00 to 0x30000 -> no push, tx_valid stays 0.
REQ-034 Read 0x30004..0x30007 100 cycles after reset release -> bytes reassemble to the snapshot value taken at the 0x30004 read (about 100).
REQ-035 Write any byte to 0x30004 with 3 bytes queued and tx_ready=1 -> 0x00 is sent last, then sim_done=1; a later 0x30000 write is ignored.
REQ-036 rx_valid=1, rx_data=0x37, read 0x30000 -> mem_din=0x37 next cycle and a one-cycle rx_pop; with rdy_in=0 the same read -> no rx_pop, mem_din unchanged.
